// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU opcodes and the control-bundle layout
// carried from decode through the ID/EX register.
package pipeline_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;

  localparam int CTRL_W          = 6;
  localparam int CTRL_ALU_SRC    = 0;
  localparam int CTRL_REG_DST    = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_TO_REG = 5;

  // A bubble carries this bundle: no write, no memory access.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Register 0 never produces a hazard.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  output logic              load_use
);

  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rt != '0) &
               ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// EX hold and stall/bubble performance counters.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rd_data1,
  input  logic [DATA_W-1:0]  id_rd_data2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               flush,
  input  logic               ex_hold,
  output logic               stall_ifid,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_q;
  logic              flush_pend;
  logic              kill;
  logic              load_use_raw;
  logic              load_use;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use_raw)
  );

  always_comb begin
    ctrl_in                  = CTRL_NOP;
    ctrl_in[CTRL_ALU_SRC]    = id_alu_src;
    ctrl_in[CTRL_REG_DST]    = id_reg_dst;
    ctrl_in[CTRL_MEM_READ]   = id_mem_read;
    ctrl_in[CTRL_MEM_WRITE]  = id_mem_write;
    ctrl_in[CTRL_REG_WRITE]  = id_reg_write;
    ctrl_in[CTRL_MEM_TO_REG] = id_mem_to_reg;
  end

  assign kill     = flush | flush_pend;
  assign load_use = load_use_raw & id_valid;
  // Gated by reset_n so an ex_hold arriving during reset does not stall IF/ID.
  assign stall_ifid = reset_n & (ex_hold | (load_use & ~kill));

  // ID -> EX register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_alu_op  <= '0;
      ctrl_q     <= CTRL_NOP;
    end else if (ex_hold) begin
      ex_valid <= ex_valid;
    end else if (kill || load_use) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_alu_op  <= '0;
      ctrl_q     <= CTRL_NOP;
    end else begin
      ex_valid   <= id_valid;
      ex_pc      <= id_pc;
      ex_rs_data <= id_rd_data1;
      ex_rt_data <= id_rd_data2;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_alu_op  <= id_alu_op;
      ctrl_q     <= id_valid ? ctrl_in : CTRL_NOP;
    end
  end

  // Counters and the flush remembered across an EX hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_pend <= 1'b0;
    end else if (ex_hold) begin
      stall_cnt <= stall_cnt + CNT_ONE;
      if (flush) flush_pend <= 1'b1;
    end else if (kill) begin
      flush_pend <= 1'b0;
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end else if (load_use) begin
      stall_cnt  <= stall_cnt + CNT_ONE;
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

  assign ex_alu_src    = ctrl_q[CTRL_ALU_SRC];
  assign ex_reg_dst    = ctrl_q[CTRL_REG_DST];
  assign ex_mem_read   = ctrl_q[CTRL_MEM_READ];
  assign ex_mem_write  = ctrl_q[CTRL_MEM_WRITE];
  assign ex_reg_write  = ctrl_q[CTRL_REG_WRITE];
  assign ex_mem_to_reg = ctrl_q[CTRL_MEM_TO_REG];

endmodule
